// File: rtl/cbb_pulse_pacer.sv
// Event pacer feeding a CDC pulse synchronizer: queues incoming strobes and
// re-emits them as registered single-cycle pulses at least P_MIN_GAP cycles apart.
module cbb_pulse_pacer #(
    parameter int P_MIN_GAP = 8,
    parameter int P_CNT_W   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pulse,
    input  logic               i_flush,
    input  logic               i_ovf_clr,
    output logic               o_pulse,
    output logic [P_CNT_W-1:0] o_pending,
    output logic               o_busy,
    output logic               o_ovf
);

    localparam int TW = $clog2(P_MIN_GAP);
    localparam logic [TW-1:0]      GAP_RELOAD = TW'(P_MIN_GAP - 1);
    localparam logic [P_CNT_W-1:0] CNT_MAX    = {P_CNT_W{1'b1}};

    logic               pulse_q, pulse_d;
    logic [P_CNT_W-1:0] pend_q, pend_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               ovf_q, ovf_d;
    logic               issue_s;
    logic               ovf_set_s;

    // Next-state logic for issue decision, gap timer, backlog counter and overflow flag
    always_comb begin
        issue_s   = 1'b0;
        ovf_set_s = 1'b0;
        pend_d    = pend_q;
        timer_d   = timer_q;
        ovf_d     = ovf_q;

        if ((timer_q == '0) && ((pend_q != '0) || i_pulse) && !i_flush) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end

        // The timer is deliberately left running through a flush so spacing is kept
        if (issue_s) begin
            timer_d = GAP_RELOAD;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
        end else begin
            timer_d = timer_q;
        end

        if (i_flush) begin
            pend_d = '0;
        end else if (i_pulse && !issue_s) begin
            if (pend_q == CNT_MAX) begin
                pend_d    = pend_q;
                ovf_set_s = 1'b1;
            end else begin
                pend_d = pend_q + P_CNT_W'(1);
            end
        end else if (issue_s && !i_pulse) begin
            pend_d = pend_q - P_CNT_W'(1);
        end else begin
            pend_d = pend_q;
        end

        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        pulse_d = issue_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pulse_q <= 1'b0;
            pend_q  <= '0;
            timer_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_pulse   = pulse_q;
    assign o_pending = pend_q;
    assign o_ovf     = ovf_q;
    assign o_busy    = (pend_q != '0) | (timer_q != '0) | pulse_q;

endmodule

// File: tb/tb_cbb_pulse_pacer.sv
// Scoreboard bench for cbb_pulse_pacer: directed scenarios plus random traffic,
// checked against a cycle-count reference model.
module tb_cbb_pulse_pacer;

    localparam int GAP  = 4;
    localparam int CW   = 3;
    localparam int PMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst, pulse_in, flush, ovf_clr;
    logic          o_pulse, o_busy, o_ovf;
    logic [CW-1:0] o_pending;

    typedef struct {
        int cyc;
        bit pulse;
        int pend;
        bit busy;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int npulse = 0;

    // Reference model state: backlog as an integer, cycle index of the last emission
    int k      = 0;
    int m_pend = 0;
    int m_last = -1000;
    bit m_ovf  = 1'b0;

    cbb_pulse_pacer #(.P_MIN_GAP(GAP), .P_CNT_W(CW)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_pulse  (pulse_in),
        .i_flush  (flush),
        .i_ovf_clr(ovf_clr),
        .o_pulse  (o_pulse),
        .o_pending(o_pending),
        .o_busy   (o_busy),
        .o_ovf    (o_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int cyc, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, want);
        end
    endtask

    // Apply one cycle of inputs and push the model's prediction for the following cycle
    task automatic step(input bit r, input bit p, input bit f, input bit c);
        exp_t e;
        bit   iss;
        @(negedge clk);
        rst = r; pulse_in = p; flush = f; ovf_clr = c;
        iss = 1'b0;
        if (r) begin
            m_pend = 0;
            m_last = -1000;
            m_ovf  = 1'b0;
        end else begin
            iss = (k - m_last >= GAP) && (m_pend > 0 || p) && !f;
            if (iss) m_last = k;
            if (f) begin
                m_pend = 0;
            end else begin
                m_pend = m_pend + int'(p) - int'(iss);
                if (m_pend > PMAX) begin
                    m_pend = PMAX;
                    m_ovf  = 1'b1;
                end else if (c) begin
                    m_ovf = 1'b0;
                end
            end
            if (f && c) m_ovf = 1'b0;
        end
        e.cyc   = k + 1;
        e.pulse = iss;
        e.pend  = m_pend;
        e.ovf   = m_ovf;
        e.busy  = (m_pend != 0) || iss || ((k + 1 - m_last >= 1) && (k + 1 - m_last <= GAP - 1));
        exp_q.push_back(e);
        k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it with the queue head
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (o_pulse === 1'b1) npulse++;
            check("o_pulse",   e.cyc, int'(o_pulse === 1'b1), int'(e.pulse));
            check("o_pending", e.cyc, (^o_pending === 1'bx) ? -1 : int'(o_pending), e.pend);
            check("o_busy",    e.cyc, int'(o_busy === 1'b1), int'(e.busy));
            check("o_ovf",     e.cyc, int'(o_ovf === 1'b1), int'(e.ovf));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; pulse_in = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(8);

        // Single event
        base = npulse;
        burst(1);
        idle(12);
        check("single_count", k, npulse - base, 1);

        // Burst of five, fully paced
        base = npulse;
        burst(5);
        idle(30);
        check("burst_count", k, npulse - base, 5);

        // Overflow: twelve events into a seven-deep backlog, two dropped
        base = npulse;
        burst(12);
        idle(50);
        check("ovf_count", k, npulse - base, 10);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);

        // Set wins over a coincident clear, then a lone clear
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, (i == 10));
        idle(20);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(30);

        // Flush mid-backlog, then a new event honouring the running gap timer
        base = npulse;
        burst(5);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        burst(1);
        idle(12);
        check("flush_count", k, npulse - base, 3);

        // Reset mid-backlog
        base = npulse;
        burst(5);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        burst(1);
        idle(12);
        check("reset_count", k, npulse - base, 3);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 5));
        end
        idle(40);

        @(negedge clk);
        check("queue_drained", k, exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
